realtime_parallel_sample_gen: RTL
=================================

# realtime_parallel_sample_gen

Synthesizable multi-channel realtime stimulus source: on a start pulse, each of `CHANNELS` parallel no-backpressure (valid-only, no ready) lanes emits exactly `n_samples` ramp samples, either every cycle or on per-channel pseudo-random cycles. It drives a realtime parallel stream consumer directly (same data/valid layout as the team's realtime parallel interface), for on-chip self-test of DAQ datapaths and hardware-in-loop benches where a simulation-only stimulus task is unavailable.

## Interface
Parameters:
- `DWIDTH`, 32, sample width per channel
- `CHANNELS`, 4, number of parallel lanes
- `CNT_WIDTH`, 16, width of sample counters and `n_samples`
- `CHANNEL_STRIDE`, 1024, data offset between adjacent channels
- `SEED`, 16'hACE1, base LFSR seed

Ports:
- `clk`  in  1  sole clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle pulse; begins a burst when idle
- `stop`  in  1  aborts a running burst
- `n_samples`  in  `CNT_WIDTH`  samples per channel, sampled with `start`
- `rand_arrivals`  in  1  0 = valid every cycle, 1 = LFSR-gated; sampled with `start`
- `data`  out  `CHANNELS*DWIDTH`  lane i at bits [i*DWIDTH +: DWIDTH]
- `valid`  out  `CHANNELS`  per-lane sample strobe
- `last`  out  `CHANNELS`  high with lane's final sample
- `done`  out  `CHANNELS`  lane i has sent all samples (sticky until next start/reset)
- `busy`  out  1  burst in progress
- `done_all`  out  1  one-cycle pulse at burst completion or abort

## Operation
- States: IDLE, RUN. All outputs registered.
- IDLE: `valid`=0, `last`=0, `busy`=0. On `start`: latch `n_samples`, `rand_arrivals`; clear counters and `done`; if `n_samples`=0 set `done`='1, pulse `done_all`, stay IDLE; else go RUN.
- RUN, per lane i with `done[i]`=0: eligible = 1 if not random, else `lfsr_i[0]`. If eligible: `valid[i]`=1, `data[i]` = (i*`CHANNEL_STRIDE` + cnt_i) mod 2^DWIDTH; if cnt_i = n-1 assert `last[i]` and set `done[i]`, else cnt_i++. Lanes with `done[i]`=1 hold `valid[i]`=0.
- When every `done` bit is set: next cycle RUN->IDLE, `done_all` pulses, `busy` drops.
- `start` while RUN ignored. `stop` in RUN: next cycle `valid`/`last`=0, IDLE, `done_all` pulse, `done` keeps partial state. `stop` in IDLE ignored; `stop` and `start` same cycle in IDLE: start wins.
- LFSR per lane: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifts every RUN cycle; reloaded on `start` with `SEED ^ (i+1)`, forced to 16'h0001 if result is zero.
- `data` for non-valid lanes is don't-care; implementation holds previous value.
- Counter arithmetic in `CNT_WIDTH` bits; `n_samples` up to 2^CNT_WIDTH-1 supported; no wrap within a burst.

## Timing
- Reset (synchronous): all outputs 0, state IDLE, counters and LFSRs cleared; takes effect the cycle `reset` is sampled high, including mid-burst (no `done_all` pulse).
- `start` sampled at edge t -> first `valid` at t+1, `busy`=1 from t+1.
- `rand_arrivals`=0: each lane valid on cycles t+1..t+n, `last` at t+n, `done` set at t+n+1 (registered with last sample edge), `done_all` pulse and `busy`=0 at t+n+1.
- `rand_arrivals`=1: per-lane completion independent; `done_all` exactly one cycle after the last lane's `last` cycle.
- `stop` sampled at s -> `valid`=0 and `done_all`=1 at s+1.
- `n_samples`=0 start at t: `done`='1 and `done_all` at t+1, `valid` never asserted.

## Test plan
- CHANNELS=4, n_samples=8, rand=0 -> each lane valid 8 consecutive cycles, lane 2 data 2048..2055, `last` on 8th, `done_all` one cycle later.
- n_samples=100, rand=1 -> each lane exactly 100 valid beats, data gapless ramp per lane, `done_all` once, one cycle after final `last`.
- n_samples=0 -> no `valid`, `done`=4'hF and `done_all` pulse one cycle after `start`.
- n_samples=50, `stop` after 10 cycles (rand=0) -> 10 beats per lane, valid 0 next cycle, `done`=0, `done_all` pulse; new `start` restarts ramps at offsets 0.
- `reset` mid-burst, then `start` n=5 -> all outputs 0 after reset, no `done_all`, fresh burst of 5 samples with identical LFSR sequence as a post-reset run.
- `start` pulsed again while busy -> ignored, sample counts unchanged.

Source files
------------

// File: rtl/realtime_parallel_sample_gen.sv
// Multi-lane ramp stimulus source: on start, each lane emits n_samples ramp values
// (lane offset + count), every cycle or gated per lane by its own 16-bit LFSR.
module realtime_parallel_sample_gen #(
  parameter int          DWIDTH         = 32,
  parameter int          CHANNELS       = 4,
  parameter int          CNT_WIDTH      = 16,
  parameter int          CHANNEL_STRIDE = 1024,
  parameter logic [15:0] SEED           = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stop,
  input  logic [CNT_WIDTH-1:0]         n_samples,
  input  logic                         rand_arrivals,
  output logic [CHANNELS*DWIDTH-1:0]   data,
  output logic [CHANNELS-1:0]          valid,
  output logic [CHANNELS-1:0]          last,
  output logic [CHANNELS-1:0]          done,
  output logic                         busy,
  output logic                         done_all
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                      state_q, state_d;
  logic [CNT_WIDTH-1:0]        n_q, n_d;
  logic                        rand_q, rand_d;
  logic [CNT_WIDTH-1:0]        cnt_q [CHANNELS];
  logic [CNT_WIDTH-1:0]        cnt_d [CHANNELS];
  logic [15:0]                 lfsr_q [CHANNELS];
  logic [15:0]                 lfsr_d [CHANNELS];
  logic [CHANNELS-1:0]         fin_q, fin_d;
  logic [CHANNELS-1:0]         valid_q, valid_d;
  logic [CHANNELS-1:0]         last_q, last_d;
  logic [CHANNELS-1:0]         done_q, done_d;
  logic [CHANNELS*DWIDTH-1:0]  data_q, data_d;
  logic                        busy_q, busy_d;
  logic                        done_all_q, done_all_d;

  logic                        load, run;
  logic [CNT_WIDTH-1:0]        n_src;
  logic [15:0]                 seed_init [CHANNELS];
  logic [DWIDTH-1:0]           lane_base [CHANNELS];
  logic [CNT_WIDTH-1:0]        cnt_src [CHANNELS];
  logic [CHANNELS-1:0]         elig;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // The first sample goes out on the start edge itself, so that edge uses the
  // fresh seed and the register is loaded with the already-advanced state.
  assign load  = (state_q == IDLE) && start;
  assign run   = (state_q == RUN) && !stop && !(&fin_q);
  assign n_src = load ? n_samples : n_q;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
    localparam logic [15:0] SEED_RAW = SEED ^ 16'(gi + 1);
    assign seed_init[gi] = (SEED_RAW == 16'h0000) ? 16'h0001 : SEED_RAW;
    assign lane_base[gi] = DWIDTH'(gi) * DWIDTH'(CHANNEL_STRIDE);
    assign cnt_src[gi]   = load ? '0 : cnt_q[gi];
    assign elig[gi]      = load ? (!rand_arrivals || seed_init[gi][0])
                                : (!rand_q || lfsr_q[gi][0]);
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    rand_d     = rand_q;
    cnt_d      = cnt_q;
    lfsr_d     = lfsr_q;
    fin_d      = fin_q;
    valid_d    = '0;
    last_d     = '0;
    done_d     = done_q;
    data_d     = data_q;
    busy_d     = busy_q;
    done_all_d = 1'b0;

    if (load) begin
      n_d    = n_samples;
      rand_d = rand_arrivals;
      if (n_samples == '0) begin
        done_d     = '1;
        fin_d      = '1;
        done_all_d = 1'b1;
      end else begin
        state_d = RUN;
        busy_d  = 1'b1;
        done_d  = '0;
        fin_d   = '0;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_d[i]  = '0;
        lfsr_d[i] = lfsr_step(seed_init[i]);
      end
    end else if (state_q == RUN) begin
      done_d = fin_q;
      for (int i = 0; i < CHANNELS; i++) begin
        lfsr_d[i] = lfsr_step(lfsr_q[i]);
      end
      if (!run) begin
        state_d    = IDLE;
        busy_d     = 1'b0;
        done_all_d = 1'b1;
      end
    end

    for (int i = 0; i < CHANNELS; i++) begin
      if (elig[i] && ((load && n_samples != '0) || (run && !fin_q[i]))) begin
        valid_d[i]                    = 1'b1;
        data_d[i*DWIDTH +: DWIDTH]    = lane_base[i] + DWIDTH'(cnt_src[i]);
        if (cnt_src[i] == n_src - CNT_WIDTH'(1)) begin
          last_d[i] = 1'b1;
          fin_d[i]  = 1'b1;
        end else begin
          cnt_d[i] = cnt_src[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      n_q        <= '0;
      rand_q     <= 1'b0;
      fin_q      <= '0;
      valid_q    <= '0;
      last_q     <= '0;
      done_q     <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_all_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]  <= '0;
        lfsr_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      rand_q     <= rand_d;
      cnt_q      <= cnt_d;
      lfsr_q     <= lfsr_d;
      fin_q      <= fin_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      done_q     <= done_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_all_q <= done_all_d;
    end
  end

  assign data     = data_q;
  assign valid    = valid_q;
  assign last     = last_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign done_all = done_all_q;

endmodule
